// File: rtl/instruction_fetch_if.sv
// Handshake bundle between the fetch stage, instruction memory, the redirect source and the decoder.
// master = fetch stage, slave = environment (memory, decoder, branch unit).
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, fetch_fault,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: credit-limited sequential PC requests, DEPTH-entry {pc, word} FIFO, redirect flush.
// Optional misaligned-redirect fault is enabled by defining MISALIGN_CHECK_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fetch_entry_t;

    logic [31:0]             fetch_pc_q, fetch_pc_d;
    logic [31:0]             resp_pc_q, resp_pc_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
    logic [PW:0]             count_q, count_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    fetch_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic                    fault_q, fault_d;

    logic [31:0]   redir_pc;
    logic          redir_bad;
    logic [CW-1:0] occupancy;
    logic          req_fire, pop, push;

`ifdef MISALIGN_CHECK_EN
    assign redir_pc  = bus.redirect_pc;
    assign redir_bad = |bus.redirect_pc[1:0];
`else
    logic unused_redir_lo;
    assign unused_redir_lo = ^bus.redirect_pc[1:0];
    assign redir_pc  = {bus.redirect_pc[31:2], 2'b00};
    assign redir_bad = 1'b0;
`endif

    // Stale in-flight words still hold a slot in outstanding but will never reach the FIFO.
    assign occupancy = CW'(count_q) + outstanding_q - drop_cnt_q;

    assign bus.imem_req_valid = !rst && !bus.redirect_valid && !fault_q
                                && (occupancy < CW'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.inst_valid     = (count_q != '0);
    assign bus.inst           = mem_q[rd_ptr_q].word;
    assign bus.inst_pc        = mem_q[rd_ptr_q].pc;
    assign bus.fetch_fault    = fault_q;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign pop      = bus.inst_valid && bus.inst_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        mem_d         = mem_q;
        fault_d       = fault_q;
        push          = 1'b0;

        if (bus.redirect_valid) begin
            fetch_pc_d    = redir_pc;
            resp_pc_d     = redir_pc;
            count_d       = '0;
            rd_ptr_d      = '0;
            wr_ptr_d      = '0;
            fault_d       = redir_bad;
            outstanding_d = outstanding_q - CW'(bus.imem_resp_valid);
            // Every surviving in-flight request is now stale; outstanding already includes
            // the ones an earlier redirect marked, so this also covers back-to-back redirects.
            drop_cnt_d    = outstanding_q - CW'(bus.imem_resp_valid);
        end else begin
            if (req_fire)
                fetch_pc_d = fetch_pc_q + 32'd4;
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_resp_valid);
            if (bus.imem_resp_valid) begin
                if (drop_cnt_q != '0)
                    drop_cnt_d = drop_cnt_q - CW'(1);
                else
                    push = 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q].pc   = resp_pc_q;
                mem_d[wr_ptr_q].word = bus.imem_resp_data;
                wr_ptr_d             = wr_ptr_q + PW'(1);
                resp_pc_d            = resp_pc_q + 32'd4;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            fault_q       <= fault_d;
        end
    end
endmodule
